// File: rtl/calc_dispatcher.sv
// -----------------------------------------------------------------------------
// calc_dispatcher
// Sequences one matrix calculation. It latches the operating mode and
// calculation type on a confirm pulse, requests one or two operands, fires a
// single-cycle launch pulse to the compute unit, and then waits for
// done/error under a watchdog. The outcome stays on `status` until the next
// start pulse.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   asynchronous, active-high reset
//   op_mode[2:0]  in   operand mode (single / double / scalar)
//   calc_type[2:0]in   calculation selector, latched at start
//   start         in   confirm pulse (accepted in IDLE and REPORT)
//   abort         in   cancel pulse (COLLECT, LAUNCH, WAIT)
//   operand_valid in   one operand accepted
//   calc_done     in   compute-unit completion pulse
//   calc_err      in   compute-unit error pulse
//   operand_req   out  operands are being awaited
//   operand_idx   out  index of the operand currently requested
//   calc_start    out  single-cycle launch pulse
//   calc_sel[2:0] out  latched calc_type, cleared on return to IDLE
//   busy          out  high in every state except IDLE
//   status[1:0]   out  00 idle, 01 ok, 10 error, 11 timeout
//
// state   | meaning
// IDLE    | waiting for start; status keeps the previous outcome
// COLLECT | requesting operands, operand_idx counts accepted ones
// LAUNCH  | one cycle, calc_start high, watchdog cleared
// WAIT    | compute unit running, watchdog counting
// REPORT  | one cycle after an outcome, then IDLE (status is held)
// -----------------------------------------------------------------------------
module calc_dispatcher #(
  parameter int TIMEOUT_CYCLES = 25000000,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op_mode,
  input  logic [2:0] calc_type,
  input  logic       start,
  input  logic       abort,
  input  logic       operand_valid,
  input  logic       calc_done,
  input  logic       calc_err,
  output logic       operand_req,
  output logic       operand_idx,
  output logic       calc_start,
  output logic [2:0] calc_sel,
  output logic       busy,
  output logic [1:0] status
);

  localparam logic [2:0] OP_SINGLE = 3'd1;
  localparam logic [2:0] OP_DOUBLE = 3'd2;
  localparam logic [2:0] OP_SCALAR = 3'd3;

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_OK   = 2'b01;
  localparam logic [1:0] STAT_ERR  = 2'b10;
  localparam logic [1:0] STAT_TMO  = 2'b11;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT    = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_need;
  logic [1:0]       r_got;
  logic [CNT_W-1:0] r_wd;
  logic [2:0]       r_calc_sel;
  logic [1:0]       r_status;

  logic             w_start_ok;
  logic             w_mode_ok;
  logic             w_in_flight;
  logic             w_abort;
  logic             w_last_op;
  logic [CNT_W-1:0] w_wd_nxt;
  logic             w_timeout;

  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_REPORT));
  assign w_mode_ok   = (op_mode == OP_SINGLE) || (op_mode == OP_DOUBLE) ||
                       (op_mode == OP_SCALAR);
  assign w_in_flight = (r_state == S_COLLECT) || (r_state == S_LAUNCH) ||
                       (r_state == S_WAIT);
  assign w_abort     = abort && w_in_flight;
  assign w_last_op   = operand_valid && ((r_got + 2'd1) == r_need);

  // Saturating watchdog; timeout fires on the cycle the count reaches the
  // limit, so the outcome appears TIMEOUT_CYCLES cycles after calc_start.
  assign w_wd_nxt  = (r_wd == '1) ? r_wd : r_wd + CNT_W'(1);
  assign w_timeout = (w_wd_nxt >= WD_LAST);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = w_mode_ok ? S_COLLECT : S_REPORT;
      end
      S_COLLECT: begin
        if (abort)          w_state_nxt = S_IDLE;
        else if (w_last_op) w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_state_nxt = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort)                                  w_state_nxt = S_IDLE;
        else if (calc_err || calc_done || w_timeout) w_state_nxt = S_REPORT;
      end
      S_REPORT: begin
        if (start) w_state_nxt = w_mode_ok ? S_COLLECT : S_REPORT;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    operand_req = (r_state == S_COLLECT);
    operand_idx = (r_state == S_COLLECT) && r_got[0];
    calc_start  = (r_state == S_LAUNCH);
    busy        = (r_state != S_IDLE);
    calc_sel    = r_calc_sel;
    status      = r_status;
  end

  // latched context, operand counter, watchdog and outcome
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_need     <= 2'd0;
      r_got      <= 2'd0;
      r_wd       <= '0;
      r_calc_sel <= 3'd0;
      r_status   <= STAT_IDLE;
    end else begin
      if (r_state == S_WAIT) r_wd <= w_wd_nxt;
      else                   r_wd <= '0;

      if (w_start_ok) begin
        r_calc_sel <= calc_type;
        r_got      <= 2'd0;
        r_need     <= (op_mode == OP_SINGLE) ? 2'd1 : 2'd2;
        r_status   <= w_mode_ok ? STAT_IDLE : STAT_ERR;
      end else if (w_abort) begin
        r_calc_sel <= 3'd0;
        r_got      <= 2'd0;
        r_status   <= STAT_IDLE;
      end else begin
        if ((r_state == S_COLLECT) && operand_valid) r_got <= r_got + 2'd1;
        if (r_state == S_WAIT) begin
          if (calc_err)       r_status <= STAT_ERR;
          else if (calc_done) r_status <= STAT_OK;
          else if (w_timeout) r_status <= STAT_TMO;
        end
        // REPORT without a new start returns to IDLE: drop the selection
        if (r_state == S_REPORT) r_calc_sel <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_calc_dispatcher.sv
module tb_calc_dispatcher;

  localparam logic [2:0] OP_SINGLE      = 3'd1;
  localparam logic [2:0] OP_DOUBLE      = 3'd2;
  localparam logic [2:0] OP_SCALAR      = 3'd3;
  localparam logic [2:0] CALC_ADD       = 3'd0;
  localparam logic [2:0] CALC_MUL       = 3'd2;
  localparam logic [2:0] CALC_TRANSPOSE = 3'd4;
  localparam logic [2:0] CALC_DET       = 3'd6;

  logic       clk;
  logic       rst;
  logic [2:0] op_mode;
  logic [2:0] calc_type;
  logic       start;
  logic       abort;
  logic       operand_valid;
  logic       calc_done;
  logic       calc_err;

  // index 0: long watchdog (64), index 1: short watchdog (16)
  logic       o_req    [2];
  logic       o_idx    [2];
  logic       o_cstart [2];
  logic [2:0] o_sel    [2];
  logic       o_busy   [2];
  logic [1:0] o_status [2];

  int n_checks = 0;
  int n_errors = 0;

  calc_dispatcher #(.TIMEOUT_CYCLES(64), .CNT_W(8)) u_dut_long (
    .clk(clk), .rst(rst), .op_mode(op_mode), .calc_type(calc_type),
    .start(start), .abort(abort), .operand_valid(operand_valid),
    .calc_done(calc_done), .calc_err(calc_err),
    .operand_req(o_req[0]), .operand_idx(o_idx[0]), .calc_start(o_cstart[0]),
    .calc_sel(o_sel[0]), .busy(o_busy[0]), .status(o_status[0])
  );

  calc_dispatcher #(.TIMEOUT_CYCLES(16), .CNT_W(8)) u_dut_short (
    .clk(clk), .rst(rst), .op_mode(op_mode), .calc_type(calc_type),
    .start(start), .abort(abort), .operand_valid(operand_valid),
    .calc_done(calc_done), .calc_err(calc_err),
    .operand_req(o_req[1]), .operand_idx(o_idx[1]), .calc_start(o_cstart[1]),
    .calc_sel(o_sel[1]), .busy(o_busy[1]), .status(o_status[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_of(int i);
    return (i == 0) ? 64 : 16;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: operands still owed, cycles elapsed since the
  // launch pulse, and the outcome word.
  int       m_left  [2];
  int       m_got   [2];
  int       m_age   [2];
  bit       m_fire  [2];
  bit       m_flash [2];
  bit [1:0] m_status[2];
  bit [2:0] m_sel   [2];

  task automatic model_clear(input int i);
    m_left[i] = 0; m_got[i] = 0; m_age[i] = 0;
    m_fire[i] = 0; m_flash[i] = 0;
  endtask

  task automatic model_step(input int i);
    bit in_flight;
    in_flight = (m_left[i] > 0) || m_fire[i] || (m_age[i] > 0);
    if (in_flight && abort) begin
      model_clear(i);
      m_status[i] = 2'b00;
      m_sel[i]    = 3'd0;
    end else if (m_left[i] > 0) begin
      if (operand_valid) begin
        m_got[i]++;
        m_left[i]--;
        if (m_left[i] == 0) m_fire[i] = 1;
      end
    end else if (m_fire[i]) begin
      m_fire[i] = 0;
      m_age[i]  = 1;
    end else if (m_age[i] > 0) begin
      if (calc_err) begin
        m_status[i] = 2'b10; m_age[i] = 0; m_flash[i] = 1;
      end else if (calc_done) begin
        m_status[i] = 2'b01; m_age[i] = 0; m_flash[i] = 1;
      end else if (m_age[i] + 1 >= to_of(i)) begin
        m_status[i] = 2'b11; m_age[i] = 0; m_flash[i] = 1;
      end else begin
        m_age[i]++;
      end
    end else if (start) begin
      m_status[i] = 2'b00;
      m_sel[i]    = calc_type;
      m_got[i]    = 0;
      m_flash[i]  = 0;
      if (op_mode == OP_SINGLE) m_left[i] = 1;
      else if (op_mode == OP_DOUBLE || op_mode == OP_SCALAR) m_left[i] = 2;
      else begin
        m_status[i] = 2'b10;
        m_flash[i]  = 1;
      end
    end else if (m_flash[i]) begin
      m_flash[i] = 0;
      m_sel[i]   = 3'd0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        model_clear(i);
        m_status[i] = 2'b00;
        m_sel[i]    = 3'd0;
      end else begin
        model_step(i);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d.operand_req", i), o_req[i], m_left[i] > 0);
      chk($sformatf("dut%0d.operand_idx", i), o_idx[i],
          (m_left[i] > 0) ? (m_got[i] % 2) : 0);
      chk($sformatf("dut%0d.calc_start", i), o_cstart[i], m_fire[i]);
      chk($sformatf("dut%0d.busy", i), o_busy[i],
          (m_left[i] > 0) || m_fire[i] || (m_age[i] > 0) || m_flash[i]);
      chk($sformatf("dut%0d.calc_sel", i), o_sel[i], m_sel[i]);
      chk($sformatf("dut%0d.status", i), o_status[i], m_status[i]);
    end
  end

  task automatic step1();
    @(posedge clk);
    #2;
    start = 0; abort = 0; operand_valid = 0; calc_done = 0; calc_err = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step1();
  endtask

  initial begin
    rst = 0; start = 0; abort = 0; operand_valid = 0; calc_done = 0; calc_err = 0;
    op_mode = OP_SINGLE; calc_type = CALC_ADD;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset busy", o_busy[0], 1'b0);
    chk("reset status", o_status[0], 2'b00);
    rst = 0;
    idle(3);
    chk("idle after reset", o_busy[0], 1'b0);

    // double operand multiply: operands at cycles 3 and 7, done 20 after launch
    op_mode = OP_DOUBLE; calc_type = CALC_MUL; start = 1;   // cycle 0
    step1();                                                 // cycle 1
    chk("s1 req", o_req[0], 1'b1);
    chk("s1 idx0", o_idx[0], 1'b0);
    idle(2);                                                 // cycle 3
    operand_valid = 1;
    step1();                                                 // cycle 4
    chk("s1 idx1", o_idx[0], 1'b1);
    op_mode = OP_SINGLE; calc_type = CALC_ADD;
    idle(3);                                                 // cycle 7
    operand_valid = 1;
    chk("s1 no early start", o_cstart[0], 1'b0);
    step1();                                                 // cycle 8
    chk("s1 calc_start c8", o_cstart[0], 1'b1);
    chk("s1 calc_sel", o_sel[0], CALC_MUL);
    idle(15);                                                // cycle 23
    chk("s1 short not yet timeout", o_status[1], 2'b00);
    step1();                                                 // cycle 24
    chk("s1 short timeout", o_status[1], 2'b11);
    idle(4);                                                 // cycle 28
    calc_done = 1;
    step1();                                                 // cycle 29
    chk("s1 long ok", o_status[0], 2'b01);
    chk("s1 short done ignored", o_status[1], 2'b11);
    step1();                                                 // cycle 30
    chk("s1 busy after done", o_busy[0], 1'b0);
    chk("s1 status held", o_status[0], 2'b01);

    // single operand transpose, mode change mid-collect ignored
    op_mode = OP_SINGLE; calc_type = CALC_TRANSPOSE; start = 1;
    step1();
    op_mode = OP_SCALAR; calc_type = CALC_MUL;
    chk("s2 req", o_req[0], 1'b1);
    step1();
    operand_valid = 1;
    step1();
    chk("s2 one operand launch", o_cstart[0], 1'b1);
    chk("s2 req dropped", o_req[0], 1'b0);
    chk("s2 calc_sel", o_sel[0], CALC_TRANSPOSE);
    step1();
    operand_valid = 1; start = 1;
    idle(2);
    calc_done = 1;
    step1();
    chk("s2 ok", o_status[0], 2'b01);
    step1();

    // done and err together; restart from REPORT; abort in LAUNCH
    op_mode = OP_SCALAR; calc_type = CALC_MUL; start = 1;
    step1();
    operand_valid = 1;
    step1();
    operand_valid = 1;
    step1();
    chk("s3 launch", o_cstart[0], 1'b1);
    step1();
    calc_done = 1; calc_err = 1;
    step1();
    chk("s3 err wins", o_status[0], 2'b10);
    op_mode = OP_SINGLE; calc_type = CALC_DET; start = 1;
    step1();
    chk("s3 restart status", o_status[0], 2'b00);
    chk("s3 restart sel", o_sel[0], CALC_DET);
    operand_valid = 1;
    step1();
    abort = 1;
    chk("s3 abort launch start", o_cstart[0], 1'b1);
    step1();
    chk("s3 abort busy", o_busy[0], 1'b0);

    // unsupported op_mode
    op_mode = 3'd6; start = 1;
    step1();
    chk("s4 bad mode status", o_status[0], 2'b10);
    chk("s4 bad mode req", o_req[0], 1'b0);
    step1();
    chk("s4 bad mode idle", o_busy[0], 1'b0);

    // abort in COLLECT after operand 0, then restart
    op_mode = OP_DOUBLE; calc_type = CALC_ADD; start = 1;
    step1();
    operand_valid = 1;
    step1();
    chk("s5 idx1", o_idx[0], 1'b1);
    abort = 1;
    step1();
    chk("s5 req off", o_req[0], 1'b0);
    chk("s5 status", o_status[0], 2'b00);
    chk("s5 busy", o_busy[0], 1'b0);
    idle(3);
    chk("s5 no launch", o_cstart[0], 1'b0);
    start = 1;
    step1();
    chk("s5 restart idx", o_idx[0], 1'b0);
    chk("s5 restart req", o_req[0], 1'b1);

    // reset mid-WAIT
    operand_valid = 1;
    step1();
    operand_valid = 1;
    step1();
    step1();
    step1();
    rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("s6 rst busy%0d", i), o_busy[i], 1'b0);
      chk($sformatf("s6 rst status%0d", i), o_status[i], 2'b00);
      chk($sformatf("s6 rst sel%0d", i), o_sel[i], 3'd0);
      chk($sformatf("s6 rst cstart%0d", i), o_cstart[i], 1'b0);
      chk($sformatf("s6 rst req%0d", i), o_req[i], 1'b0);
      chk($sformatf("s6 rst idx%0d", i), o_idx[i], 1'b0);
    end
    idle(2);
    rst = 0;
    idle(5);
    chk("s6 stays idle", o_busy[0], 1'b0);
    op_mode = OP_SINGLE; start = 1;
    step1();
    chk("s6 start after reset", o_busy[0], 1'b1);
    abort = 1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
